// File: rtl/dot_product_mac.sv
// dot_product_mac
//   Multi-lane multiply-accumulate engine. Each accepted beat multiplies LANES
//   pairs of x/w elements, sums them in an adder tree (pipeline stage 1), then
//   adds that sum into a wide accumulator (stage 2). After the last beat the
//   pipeline drains for two cycles and the result is held until it is taken.
//
//   Build option: define MAC_SATURATE_EN to clamp the accumulator at the range
//   limits on overflow; without it the accumulator wraps modulo 2^ACC_W. The
//   sticky overflow flag behaves identically in both builds.
//
//   Handshake: a beat transfers on a rising edge where in_valid && in_ready;
//   a result transfers on a rising edge where out_valid && out_ready. Neither
//   valid may depend on its ready; in_ready and out_valid depend on FSM state
//   only, and reset overrides both handshakes.
//
//   dbg_state / dbg_products expose the FSM state and the stage-1 lane products
//   so external checkers can bind to them.

module dot_product_mac #(
   parameter int DATA_W = 8,
   parameter int LANES  = 4,
   parameter int ACC_W  = 32,
   parameter int LEN_W  = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        signed_mode,
   input  logic [LEN_W-1:0]            len,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [LANES*DATA_W-1:0]     x,
   input  logic [LANES*DATA_W-1:0]     w,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [ACC_W-1:0]            result,
   output logic                        overflow,
   output logic                        busy,
   output logic [1:0]                  dbg_state,
   output logic [LANES*2*DATA_W-1:0]   dbg_products
);

   // Width bookkeeping. The stage-2 adder is wide enough to hold the true
   // (unwrapped) sum of any accumulator value and any stage-1 sum, in either
   // signedness, so range checks are exact even if ACC_W < SUM_W.
   localparam int LOG2L  = $clog2(LANES);
   localparam int PROD_W = 2 * DATA_W;
   localparam int SUM_W  = PROD_W + LOG2L;
   localparam int EXT_W  = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t              state, state_nx;
   logic [LEN_W-1:0]    cnt, cnt_nx;       // beats still to come in this product
   logic                drain_cnt, drain_nx;
   logic                mode_q;            // signedness captured on the first beat

   logic                beat;
   logic                first_beat;
   logic                eff_signed;

   // Stage-1 signals
   logic [LANES*PROD_W-1:0] prod_c;
   logic [SUM_W-1:0]        prod_ext [LANES];
   logic [SUM_W-1:0]        sum_c;
   logic                    s1_valid;
   logic [LANES*PROD_W-1:0] s1_prod;
   logic [SUM_W-1:0]        s1_sum;

   // Stage-2 signals
   logic [ACC_W-1:0]    acc;
   logic                ovf_q;
   logic [EXT_W-1:0]    sum_ext;
   logic [EXT_W-1:0]    acc_ext;
   logic [EXT_W-1:0]    add_full;
   logic                add_ovf;
   logic [ACC_W-1:0]    acc_nx;

   assign beat       = in_valid && in_ready;
   assign first_beat = (state == IDLE) && in_valid;
   // The first beat is multiplied in the same cycle its mode is captured, so it
   // must see the live input rather than the register.
   assign eff_signed = (state == IDLE) ? signed_mode : mode_q;

   // ---------------------------------------------------------------- FSM
   // State, remaining-beat counter and drain counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         drain_cnt <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         drain_cnt <= drain_nx;
      end
   end

   // Next-state logic and state-decoded handshake outputs.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      drain_nx  = drain_cnt;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               drain_nx = 1'b0;
               // len of 0 is treated as a single-beat product
               if (len <= LEN_W'(1)) begin
                  state_nx = DRAIN;
                  cnt_nx   = '0;
               end else begin
                  state_nx = ACCUM;
                  cnt_nx   = len - LEN_W'(1);
               end
            end
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid) begin
               cnt_nx = cnt - LEN_W'(1);
               if (cnt == LEN_W'(1)) begin
                  state_nx = DRAIN;
                  drain_nx = 1'b0;
               end
            end
         end
         DRAIN: begin
            // two cycles: stage 2 absorbs the last beat, then the result settles
            if (drain_cnt) begin
               state_nx = HOLD;
               drain_nx = 1'b0;
            end else begin
               drain_nx = 1'b1;
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Capture the operand signedness on the first beat of each product.
   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q <= 1'b0;
      end else if (first_beat) begin
         mode_q <= signed_mode;
      end
   end

   // ---------------------------------------------------------------- stage 1
   // Per-lane multiply. Operands are extended by one bit (sign or zero) so one
   // signed multiplier serves both modes; the product always fits in PROD_W
   // bits and resizing to SUM_W preserves its value in either mode.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic signed [DATA_W:0]     xe;
      logic signed [DATA_W:0]     we;
      logic signed [2*DATA_W+1:0] pe;
      assign xe = {eff_signed & x[i*DATA_W + DATA_W-1], x[i*DATA_W +: DATA_W]};
      assign we = {eff_signed & w[i*DATA_W + DATA_W-1], w[i*DATA_W +: DATA_W]};
      assign pe = xe * we;
      assign prod_c[i*PROD_W +: PROD_W] = pe[PROD_W-1:0];
      assign prod_ext[i] = SUM_W'(pe);
   end

   // Adder tree over the lane products; modular addition at SUM_W bits gives
   // the exact sum in both signed and unsigned interpretation.
   always_comb begin
      sum_c = '0;
      for (int i = 0; i < LANES; i++) begin
         sum_c = sum_c + prod_ext[i];
      end
   end

   // Stage-1 register: lane products and tree sum, only on accepted beats.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_prod  <= '0;
         s1_sum   <= '0;
      end else begin
         s1_valid <= beat;
         if (beat) begin
            s1_prod <= prod_c;
            s1_sum  <= sum_c;
         end
      end
   end

   // ---------------------------------------------------------------- stage 2
   // Extend both operands per the captured mode and add at full precision.
   assign sum_ext  = {{(EXT_W-SUM_W){mode_q & s1_sum[SUM_W-1]}}, s1_sum};
   assign acc_ext  = {{(EXT_W-ACC_W){mode_q & acc[ACC_W-1]}}, acc};
   assign add_full = sum_ext + acc_ext;

   // Out of range when the bits above the ACC_W field are not a pure sign
   // extension (signed) or are not all zero (unsigned; the sum is never
   // negative there).
   assign add_ovf = mode_q
      ? !((&add_full[EXT_W-1:ACC_W-1]) || !(|add_full[EXT_W-1:ACC_W-1]))
      : (|add_full[EXT_W-1:ACC_W]);

`ifdef MAC_SATURATE_EN
   // Clamp to the limit on the side the true sum went out of range.
   always_comb begin
      acc_nx = add_full[ACC_W-1:0];
      if (add_ovf) begin
         if (mode_q) begin
            acc_nx = add_full[EXT_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                       : {1'b0, {(ACC_W-1){1'b1}}};
         end else begin
            acc_nx = '1;
         end
      end
   end
`else
   // Wrap modulo 2^ACC_W.
   assign acc_nx = add_full[ACC_W-1:0];
`endif

   // Accumulator and sticky overflow. The first beat clears both; its own
   // contribution arrives one cycle later through stage 2, so a clear and an
   // add never coincide.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc   <= '0;
         ovf_q <= 1'b0;
      end else if (first_beat) begin
         acc   <= '0;
         ovf_q <= 1'b0;
      end else if (s1_valid) begin
         acc <= acc_nx;
         if (add_ovf) begin
            ovf_q <= 1'b1;
         end
      end
   end

   assign result       = acc;
   assign overflow     = ovf_q;
   assign dbg_state    = state;
   assign dbg_products = s1_prod;

endmodule
